// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed multiply (radix-2 Booth) and divide
// (restoring, on magnitudes) with registered result, exception and tag.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for ctrl_MULT / ctrl_DIV
// MUL   | one Booth add/sub + arithmetic shift per cycle
// DIV   | one restoring quotient bit per cycle
// DONE  | data_resultRDY pulse, back to IDLE next cycle
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       rd_in,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [4:0]       rd_out,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // acc carries one guard bit above the upper product half so that adding
    // or subtracting the most negative multiplicand cannot wrap; in DIV it
    // holds the partial remainder, which also needs WIDTH+1 bits.
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             booth_q, booth_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic [4:0]       tag_q, tag_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic [4:0]       rd_out_q, rd_out_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Next-state, datapath step and output update for every state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        booth_d  = booth_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        tag_d    = tag_q;
        result_d = result_q;
        exc_d    = exc_q;
        rd_out_d = rd_out_q;
        sum      = acc_q;
        rem_sh   = '0;
        diff     = '0;

        case (state_q)
            IDLE: begin
                if (ctrl_MULT) begin
                    state_d = MUL;
                    cnt_d   = '0;
                    acc_d   = '0;
                    lo_d    = data_operandB;
                    booth_d = 1'b0;
                    a_d     = data_operandA;
                    tag_d   = rd_in;
                end else if (ctrl_DIV) begin
                    state_d = DIV;
                    cnt_d   = '0;
                    acc_d   = '0;
                    lo_d    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
                    b_d     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
                    neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    tag_d   = rd_in;
                end
            end
            MUL: begin
                case ({lo_q[0], booth_q})
                    2'b01:   sum = acc_q + {a_q[WIDTH-1], a_q};
                    2'b10:   sum = acc_q - {a_q[WIDTH-1], a_q};
                    default: sum = acc_q;
                endcase
                acc_d   = {sum[WIDTH], sum[WIDTH:1]};
                lo_d    = {sum[0], lo_q[WIDTH-1:1]};
                booth_d = lo_q[0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    result_d = lo_d;
                    exc_d    = (acc_d[WIDTH-1:0] != {WIDTH{lo_d[WIDTH-1]}});
                    rd_out_d = tag_q;
                end
            end
            DIV: begin
                if (b_q == '0) begin
                    state_d  = DONE;
                    result_d = '0;
                    exc_d    = 1'b1;
                    rd_out_d = tag_q;
                end else begin
                    rem_sh = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
                    diff   = rem_sh - {1'b0, b_q};
                    if (diff[WIDTH]) begin
                        acc_d = rem_sh;
                        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = diff;
                        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d  = DONE;
                        result_d = neg_q ? -lo_d : lo_d;
                        // Only |A| = 2^(W-1) with a positive quotient overflows
                        exc_d    = ~neg_q & lo_d[WIDTH-1];
                        rd_out_d = tag_q;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == DONE);
    end

    // All state and outputs registered; reset discards any in-flight work
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            booth_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            rd_out_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            booth_q  <= booth_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            rd_out_q <= rd_out_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign rd_out         = rd_out_q;
    assign busy           = busy_q;

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Multi-cycle signed 32-bit multiply/divide responder for the pipelined processor. The execute-stage decoder raises `ctrl_MULT` / `ctrl_DIV` for the ALU-class `mul` / `div` instructions. This block latches the operands and destination tag, iterates for up to 32 cycles, then presents the result, an exception flag and the tag for writeback. It asserts `busy` so the hazard unit can hold the pipeline.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width (iteration count = `WIDTH`)

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `ctrl_MULT`  in  1  start signed multiply; sampled on the rising edge
- `ctrl_DIV`  in  1  start signed divide; sampled on the rising edge
- `data_operandA`  in  32  multiplicand / dividend
- `data_operandB`  in  32  multiplier / divisor
- `rd_in`  in  5  destination register tag of the issuing instruction
- `data_result`  out  32  product (low 32 bits) or quotient
- `data_exception`  out  1  overflow or divide-by-zero; rstatus update is performed by writeback
- `data_resultRDY`  out  1  one-cycle pulse: result, exception and tag valid
- `rd_out`  out  5  latched destination tag
- `busy`  out  1  operation in progress (state ≠ IDLE)

## Operation
- States:
  - IDLE: accepts issue.
  - MUL: radix-2 Booth iteration.
  - DIV: restoring division on magnitudes.
  - DONE: result pulse.
- Issue from IDLE, at the rising edge:
  - Always: operands and `rd_in` are latched, the iteration counter is cleared to 0, and the matching state is entered.
  - Priority: `ctrl_MULT` wins if both start inputs are high.
  - Ignored issues: start inputs in any state other than IDLE are ignored.
- MUL:
  - 65-bit product register {upper 32, lower 32, Booth bit}.
  - One add/sub of A into the upper half per cycle, followed by an arithmetic shift right by 1.
  - After 32 iterations → DONE.
  - `data_result` = product[31:0].
  - `data_exception` = 1 iff product[63:32] is not all copies of product[31].
- DIV:
  - Entry: if B == 0, go directly to DONE with `data_result` = 0 and `data_exception` = 1.
  - Otherwise: |A| and |B| are formed and 32 restoring iterations run (shift the remainder left, subtract, set the quotient bit, restore if negative), then → DONE.
  - Quotient sign = A[31] ^ B[31]; truncates toward zero; the remainder is discarded.
  - Overflow case: A = 0x80000000 and B = 0xFFFFFFFF gives `data_result` = 0x80000000 and `data_exception` = 1.
- DONE:
  - `data_resultRDY` = 1 for exactly one cycle, then → IDLE.
- Output holding:
  - `data_result`, `data_exception` and `rd_out` are registered, updated only on entry to DONE, and held until the next DONE.
- Stall coverage: the hazard unit stalls on `busy | ctrl_MULT | ctrl_DIV`. This block does not combine the start inputs into `busy`.
- Reset: `reset_n` low forces the following immediately, including mid-operation, and in-flight work is discarded:
  - state = IDLE
  - all outputs = 0
  - counter = 0
  - internal registers = 0

## Timing
Issue sampled at edge N:
- Multiply:
  - `busy` = 1 from N to N+33.
  - `data_resultRDY` = 1 from N+32 to N+33.
- Divide, B ≠ 0: same timing as multiply.
- Divide by zero:
  - `data_resultRDY` = 1 from N+1 to N+2.
  - `busy` = 0 after N+2.
- Back-to-back operation: a new issue is accepted at the edge on which the state is IDLE again, i.e. N+33 at the earliest for a full-length operation.
- Output timing: all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Multiply, normal: issue MULT with A = 7, B = −6 (0xFFFFFFFA), rd = 5.
  - Expect `data_resultRDY` pulse at N+32 only.
  - Expect `data_result` = 0xFFFFFFD6, `data_exception` = 0, `rd_out` = 5.
- Multiply, overflow: MULT 0x00010000 × 0x00010000 → `data_result` = 0x00000000, `data_exception` = 1.
- Multiply, overflow: MULT 0x7FFFFFFF × 2 → `data_result` = 0xFFFFFFFE, `data_exception` = 1.
- Divide, signed truncation: DIV −7 / 2 → 0xFFFFFFFD (−3), `data_exception` = 0, RDY at N+32.
- Divide, signed truncation: DIV 100 / −7 → −14 (0xFFFFFFF2).
- Divide by zero: DIV 5 / 0 → RDY at N+1, `data_result` = 0, `data_exception` = 1.
- Divide overflow: DIV 0x80000000 / 0xFFFFFFFF → `data_result` = 0x80000000, `data_exception` = 1.
- Issue while busy: assert `ctrl_DIV` at N+10 during a MULT → ignored; the MULT result is unchanged at N+32.
- Simultaneous start: `ctrl_MULT` = `ctrl_DIV` = 1 in IDLE with A = 6, B = 3 → result 18, not 2.
- Reset mid-operation: pull `reset_n` low at N+10 (asynchronously, between edges).
  - Expect all outputs to go to 0 immediately and `busy` = 0.
  - After release, MULT 3 × 4 → 12 with RDY 32 cycles after issue.
